// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-column dwell, press/release debounce
// and a one-cycle KeyValid strobe. Define KEYPAD_REPEAT_EN to enable typematic repeat while held.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 2,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Key,
  output logic       KeyValid,
  output logic       KeyHeld
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_TICKS - 1);
  localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_COUNT);

  state_t     state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic [7:0] rel_cnt_q, rel_cnt_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] col_q, col_d;
  logic [3:0] key_q, key_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;

  logic       sample;
  logic       any_low;
  logic [1:0] low_idx;
  logic [1:0] nxt_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [3:0] REPEAT_DELAY = 4'd8;
  localparam logic [3:0] REPEAT_RATE  = 4'd4;
  logic [3:0] rep_cnt_q, rep_cnt_d;
`endif

  assign sample  = En && (dwell_q == DWELL_LAST);
  assign any_low = (sync2_q != 4'b1111);
  assign nxt_idx = col_idx_q + 2'd1;

  // Lowest-index low row wins so simultaneous keys in one column resolve deterministically.
  always_comb begin
    if (!sync2_q[0])      low_idx = 2'd0;
    else if (!sync2_q[1]) low_idx = 2'd1;
    else if (!sync2_q[2]) low_idx = 2'd2;
    else                  low_idx = 2'd3;
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    col_idx_d = col_idx_q;
    cand_d    = cand_q;
    col_d     = col_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif

    if (En) dwell_d = sample ? 8'd0 : dwell_q + 8'd1;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d = low_idx;
            if (DEBOUNCE_COUNT == 1) begin
              key_d     = {low_idx, col_idx_q};
              valid_d   = 1'b1;
              held_d    = 1'b1;
              state_d   = HELD;
              deb_cnt_d = 8'd0;
              rel_cnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d = 4'd0;
`endif
            end else begin
              deb_cnt_d = 8'd1;
              state_d   = DEBOUNCE;
            end
          end else begin
            col_idx_d = nxt_idx;
            col_d     = ~(4'b0001 << nxt_idx);
          end
        end
        DEBOUNCE: begin
          if (any_low && (low_idx == cand_q)) begin
            if (deb_cnt_q + 8'd1 == DEB_TARGET) begin
              key_d     = {cand_q, col_idx_q};
              valid_d   = 1'b1;
              held_d    = 1'b1;
              state_d   = HELD;
              deb_cnt_d = 8'd0;
              rel_cnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d = 4'd0;
`endif
            end else begin
              deb_cnt_d = deb_cnt_q + 8'd1;
            end
          end else begin
            state_d   = SCAN;
            deb_cnt_d = 8'd0;
            col_idx_d = nxt_idx;
            col_d     = ~(4'b0001 << nxt_idx);
          end
        end
        HELD: begin
          if (sync2_q[cand_q]) begin
            if (rel_cnt_q + 8'd1 == DEB_TARGET) begin
              held_d    = 1'b0;
              state_d   = SCAN;
              rel_cnt_d = 8'd0;
              col_idx_d = nxt_idx;
              col_d     = ~(4'b0001 << nxt_idx);
            end else begin
              rel_cnt_d = rel_cnt_q + 8'd1;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = 4'd0;
`endif
          end else begin
            rel_cnt_d = 8'd0;
`ifdef KEYPAD_REPEAT_EN
            // After the first repeat the counter restarts part-way so later pulses come every REPEAT_RATE.
            if (rep_cnt_q + 4'd1 == REPEAT_DELAY) begin
              valid_d   = 1'b1;
              rep_cnt_d = REPEAT_DELAY - REPEAT_RATE;
            end else begin
              rep_cnt_d = rep_cnt_q + 4'd1;
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= SCAN;
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      dwell_q   <= 8'd0;
      deb_cnt_q <= 8'd0;
      rel_cnt_q <= 8'd0;
      col_idx_q <= 2'd0;
      cand_q    <= 2'd0;
      col_q     <= 4'b1110;
      key_q     <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= Row;
      sync2_q   <= sync1_q;
      dwell_q   <= dwell_d;
      deb_cnt_q <= deb_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      col_idx_q <= col_idx_d;
      cand_q    <= cand_d;
      col_q     <= col_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign Col      = col_q;
  assign Key      = key_q;
  assign KeyValid = valid_q;
  assign KeyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives Row from Col,
// expected key codes are queued before the accepting sample and popped on each KeyValid.
module tb_keypad_scanner;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] Key;
  logic       KeyValid;
  logic       KeyHeld;

  logic [15:0] keys = '0;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int exp_q[$];

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_PULSES = 7;
`else
  localparam int EXP_PULSES = 4;
`endif

  always #5 Clk = ~Clk;

  keypad_scanner #(.SCAN_TICKS(2), .DEBOUNCE_COUNT(4)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Row(Row),
    .Col(Col), .Key(Key), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
  );

  // Pressed key r*4+c pulls row r low whenever column c is driven low.
  always_comb begin
    Row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Col[c]) Row[r] = 1'b0;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset && KeyValid) begin
      pulses++;
      $display("strobe t=%0t key=%0d", $time, Key);
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("key_code", int'(Key), exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    En = 1'b0;
    repeat (3) cyc();
    En = 1'b1;
    cyc();
    En = 1'b0;
  endtask

  task automatic samp(input int n);
    repeat (n) repeat (2) tick();
  endtask

  initial begin
    Reset = 1'b0;
    repeat (3) cyc();
    check("reset_col", int'(Col), 4'b1110);
    check("reset_key", int'(Key), 0);
    check("reset_valid", int'(KeyValid), 0);
    check("reset_held", int'(KeyHeld), 0);
    Reset = 1'b1;

    // idle scan: column holds for two En pulses, then rotates
    tick();
    check("col_dwell", int'(Col), 4'b1110);
    tick();
    check("col_1", int'(Col), 4'b1101);
    samp(1); check("col_2", int'(Col), 4'b1011);
    samp(1); check("col_3", int'(Col), 4'b0111);
    samp(1); check("col_wrap", int'(Col), 4'b1110);

    // key 9 (row2, col1)
    keys[9] = 1'b1;
    samp(1); check("k9_col", int'(Col), 4'b1101);
    samp(3); check("k9_held_pre", int'(KeyHeld), 0);
    exp_q.push_back(9);
    samp(1); check("k9_held", int'(KeyHeld), 1); check("k9_key", int'(Key), 9);
    cyc(); check("k9_pulse_len", int'(KeyValid), 0);
    samp(2);
    keys = '0;
    samp(3); check("k9_rel3_held", int'(KeyHeld), 1); check("k9_rel3_col", int'(Col), 4'b1101);
    samp(1); check("k9_rel4_held", int'(KeyHeld), 0); check("k9_rel4_col", int'(Col), 4'b1011);

    // bounce on key 10 (row2, col2)
    keys[10] = 1'b1;
    samp(2);
    keys[10] = 1'b0;
    samp(1); check("bounce_abort_col", int'(Col), 4'b0111);
    keys[10] = 1'b1;
    samp(3); check("bounce_return_col", int'(Col), 4'b1011);
    samp(3);
    exp_q.push_back(10);
    samp(1); check("k10_key", int'(Key), 10); check("k10_held", int'(KeyHeld), 1);
    keys = '0;
    samp(4); check("k10_rel_held", int'(KeyHeld), 0); check("k10_rel_col", int'(Col), 4'b0111);

    // rows 1 and 3 in column 2, then a column-0 key while held
    keys[6] = 1'b1; keys[14] = 1'b1;
    samp(3); check("multi_col", int'(Col), 4'b1011);
    samp(3);
    exp_q.push_back(6);
    samp(1); check("multi_key", int'(Key), 6);
    keys[0] = 1'b1;
    samp(3); check("norollover_held", int'(KeyHeld), 1); check("norollover_col", int'(Col), 4'b1011);
    keys = '0;
    samp(4); check("multi_rel_held", int'(KeyHeld), 0); check("multi_rel_col", int'(Col), 4'b0111);

    // reset during debounce with deb_cnt=3 (key 3, row0 col3)
    keys[3] = 1'b1;
    samp(3); check("deb3_col", int'(Col), 4'b0111); check("deb3_held", int'(KeyHeld), 0);
    Reset = 1'b0;
    keys = '0;
    cyc();
    check("midreset_col", int'(Col), 4'b1110);
    check("midreset_held", int'(KeyHeld), 0);
    check("midreset_valid", int'(KeyValid), 0);
    check("midreset_key", int'(Key), 0);
    Reset = 1'b1;
    samp(8); check("post_reset_held", int'(KeyHeld), 0); check("post_reset_col", int'(Col), 4'b1110);

    // key 15 held for 20 samples; repeats only when the feature is built in
    keys[15] = 1'b1;
    samp(6);
    exp_q.push_back(15);
    samp(1); check("k15_key", int'(Key), 15);
    samp(7);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(15);
`endif
    samp(1); samp(3);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(15);
`endif
    samp(1); samp(3);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(15);
`endif
    samp(1);
    keys = '0;
    samp(6); check("k15_rel_held", int'(KeyHeld), 0);

    check("sb_empty", exp_q.size(), 0);
    check("pulse_count", pulses, EXP_PULSES);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart to the four-digit seven-segment scan multiplexer. The display block drives rotating anodes. This block drives rotating active-low columns of a 4x4 matrix keypad and reads the rows back. It debounces one key press, then reports a 4-bit key code with a one-cycle valid strobe. It sits beside the game control FSM and is paced by the shared millisecond enable from the programmable timer.

Parameters:
SCAN_TICKS, 2, En pulses each column is held before its rows are sampled (range 1..255)
DEBOUNCE_COUNT, 4, consecutive matching samples needed to accept a press or a release (range 1..255)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
En  input  1  single-cycle tick enable (millisecond pulse); the block advances only on cycles where En=1
Row  input  4  keypad rows, active-low, asynchronous; double-flop synchronised inside the block
Col  output  4  keypad columns, active-low, exactly one bit low at all times
Key  output  4  last accepted key code = row_idx*4 + col_idx
KeyValid  output  1  one-cycle pulse when a new key is accepted
KeyHeld  output  1  high while the accepted key is still pressed

Behaviour:
- Reset (Reset=0 at a rising Clk edge): state=SCAN, Col=4'b1110, col_idx=0, Key=0, KeyValid=0, KeyHeld=0, all counters=0, synchroniser flops=4'b1111. Reset mid-press drops the press with no KeyValid.
- Synchronised row value: rs = Row delayed by 2 Clk cycles.
- Sample point: the dwell counter counts En pulses. On the En pulse where it reaches SCAN_TICKS-1, rs is sampled and the counter clears. En=0 freezes all state except the synchroniser and the KeyValid clear.
- SCAN state:
  - At a sample with rs==4'b1111, col_idx increments mod 4 (3 wraps to 0) and Col = ~(1<<col_idx).
  - At a sample with any rs bit low: the candidate row is the lowest-index low bit, so concurrent keys in the same column resolve to the lowest row. The column is held, deb_cnt=1, and the FSM goes to DEBOUNCE. If DEBOUNCE_COUNT==1, it accepts immediately.
- DEBOUNCE state:
  - Each sample where the candidate bit is low and it is still the lowest low bit: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_COUNT: Key = candidate code, KeyValid=1 for exactly one Clk, KeyHeld=1, go to HELD, deb_cnt=0.
  - Any mismatching sample: go to SCAN, advance to the next column, deb_cnt=0, no strobe.
- HELD state:
  - The column stays frozen.
  - Each sample with the candidate bit high: rel_cnt++.
  - Each sample with the candidate bit low: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_COUNT: KeyHeld=0, go to SCAN, advance the column.
  - Other keys pressed while HELD are ignored (no rollover).
- Latency: a clean press is accepted at the DEBOUNCE_COUNT-th sample in its column. KeyValid is asserted on the Clk after that sampling edge.
- Key holds its value until the next acceptance and is stable whenever KeyValid=1.
- Col is registered and one-hot-low in every cycle, including during reset.

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: while in HELD, after REPEAT_DELAY=8 samples with the key still down, KeyValid re-pulses (same Key) every REPEAT_RATE=4 samples until release. Both values are local constants.
- Undefined: exactly one KeyValid per press. The repeat counter logic is not synthesised.

Test Plan:
- Reset low for 3 cycles, then release with no keys and En every 4th cycle -> Col cycles 1110, 1101, 1011, 0111, 1110, changing every 2 En pulses; KeyValid never asserts.
- Hold Row=4'b1011 only while Col=4'b1101 (key row2/col1) for 6 samples -> exactly one KeyValid pulse with Key=9. KeyHeld=1 until 4 released samples, then 0 and Col advances to 1011.
- Bounce: row low for 2 samples, high for 1, low for 4 -> no strobe from the first burst; a single KeyValid with the correct code after the 4th stable sample.
- Rows 1 and 3 low together in column 2 -> Key=6 (row1). Pressing a key in column 0 during HELD produces no new strobe.
- Reset asserted during DEBOUNCE with deb_cnt=3 -> next cycle Col=1110, KeyHeld=0, KeyValid=0; no strobe follows.
- KEYPAD_REPEAT_EN defined, key 15 held for 20 samples -> KeyValid at accept, then at +8 samples and every 4 samples after (accept, +8, +12, +16); no further pulses after release.
